// File: rtl/mul_seq_16_if.sv
// mul_seq_16_if
//   Groups the start/busy/done handshake, the operands and the result of the
//   sequential 16x16 multiplier.
//   Ports (signals):
//     start   : launch request (master -> slave)
//     a, b    : 16-bit multiplicand / multiplier (master -> slave)
//     busy    : multiplier iterating (slave -> master)
//     done    : one-cycle completion pulse (slave -> master)
//     product : 32-bit result {acc, q} (slave -> master)
//     hi_nz   : product does not fit in 16 bits (slave -> master)
//   Modports: master (control unit side), slave (multiplier side).
interface mul_seq_16_if;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic        hi_nz;

  modport master (
    output start, a, b,
    input  busy, done, product, hi_nz
  );

  modport slave (
    input  start, a, b,
    output busy, done, product, hi_nz
  );
endinterface

// File: rtl/mul_seq_16.sv
// adder_16
//   16-bit ripple-carry adder shared by the sequential multiplier.
//   Ports:
//     a, b        : 16-bit addends
//     cin         : carry in
//     sum         : 16-bit sum
//     c_n         : carry out of bit 15 (17th sum bit)
//     c_n_minus_1 : carry into bit 15 (signed-overflow detection)
module adder_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        c_n,
  output logic        c_n_minus_1
);
  always_comb begin
    logic c;
    sum         = '0;
    c_n_minus_1 = 1'b0;
    c           = cin;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) c_n_minus_1 = c;
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    c_n = c;
  end
endmodule

// mul_seq_16
//   Sequential unsigned 16x16 shift-and-add multiplier. One adder_16 is
//   reused over 16 iterations; the 32-bit product appears in {acc, q}.
//   Ports:
//     clk   : clock, rising edge
//     reset : synchronous active-high reset
//     bus   : mul_seq_16_if.slave (start, a, b, busy, done, product, hi_nz)
//   Latency start-accepted -> done is 17 cycles; done lasts one cycle and
//   product is held until the next accepted start.
module mul_seq_16 (
  input  logic         clk,
  input  logic         reset,
  mul_seq_16_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] mcand_reg, mcand_next;
  logic [15:0] acc_reg, acc_next;
  logic [15:0] q_reg, q_next;
  logic [4:0]  cnt_reg, cnt_next;

  logic [15:0] add_sum;
  logic        add_cout;
  logic        add_c15_unused;

  // The single shared adder: acc + mcand, no carry in.
  adder_16 u_adder (
    .a           (acc_reg),
    .b           (mcand_reg),
    .cin         (1'b0),
    .sum         (add_sum),
    .c_n         (add_cout),
    .c_n_minus_1 (add_c15_unused)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      mcand_reg <= '0;
      acc_reg   <= '0;
      q_reg     <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      mcand_reg <= mcand_next;
      acc_reg   <= acc_next;
      q_reg     <= q_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    mcand_next = mcand_reg;
    acc_next   = acc_reg;
    q_next     = q_reg;
    cnt_next   = cnt_reg;

    case (state_reg)
      IDLE, DONE: begin
        if (bus.start) begin
          mcand_next = bus.a;
          acc_next   = '0;
          q_next     = bus.b;
          cnt_next   = '0;
          state_next = RUN;
        end else begin
          // Registers held so product stays visible after done.
          state_next = IDLE;
        end
      end

      RUN: begin
        // Shift the running sum right by one through {acc, q}; the adder
        // carry lands in acc[15] so no product bit is lost.
        if (q_reg[0]) begin
          {acc_next, q_next} = {add_cout, add_sum, q_reg[15:1]};
        end else begin
          {acc_next, q_next} = {1'b0, acc_reg, q_reg[15:1]};
        end
        cnt_next = cnt_reg + 5'd1;
        if (cnt_reg == 5'd15) begin
          state_next = DONE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.busy    = (state_reg == RUN);
  assign bus.done    = (state_reg == DONE);
  assign bus.product = {acc_reg, q_reg};
  assign bus.hi_nz   = |acc_reg;
endmodule

// File: tb/tb_mul_seq_16.sv
// tb_mul_seq_16
//   Directed and randomized checks of mul_seq_16 against plain a*b
//   arithmetic, the 17-cycle handshake timing and reset behaviour.
module tb_mul_seq_16;
  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  mul_seq_16_if bus ();

  mul_seq_16 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference model: plain unsigned arithmetic.
  function automatic logic [31:0] ref_product(input logic [15:0] x, input logic [15:0] y);
    return 32'(x) * 32'(y);
  endfunction

  // Present a start request for one edge; returns at the falling edge of
  // the first RUN cycle.
  task automatic start_op(input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = x;
    bus.b     = y;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 16'($urandom);
    bus.b     = 16'($urandom);
  endtask

  // Called in RUN cycle 1. Counts cycles until done (bounded), optionally
  // injects an ignored start at cycle inject_at, then checks the result.
  // Returns at the falling edge of the done cycle.
  task automatic wait_done(input string tag, input logic [15:0] x, input logic [15:0] y,
                           input int inject_at);
    int lat;
    int busy_n;
    logic [31:0] exp;
    lat    = 1;
    busy_n = 0;
    exp    = ref_product(x, y);
    while (!bus.done && lat < 40) begin
      if (lat == inject_at) begin
        bus.start = 1'b1;
        bus.a     = 16'd9;
        bus.b     = 16'd9;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.busy) busy_n++;
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    $display("op %s: a=%h b=%h product=%h hi_nz=%b latency=%0d busy_cycles=%0d",
             tag, x, y, bus.product, bus.hi_nz, lat, busy_n);
    check({tag, ".latency"}, 32'(lat), 32'd17);
    check({tag, ".busy_cycles"}, 32'(busy_n), 32'd16);
    check({tag, ".busy_in_done"}, 32'(bus.busy), 32'd0);
    check({tag, ".product"}, bus.product, exp);
    check({tag, ".hi_nz"}, 32'(bus.hi_nz), 32'(exp[31:16] != 16'd0));
  endtask

  // After a done cycle with no new start: done drops, result is held.
  task automatic check_after_done(input string tag, input logic [31:0] exp);
    @(negedge clk);
    check({tag, ".done_width"}, 32'(bus.done), 32'd0);
    check({tag, ".idle_busy"}, 32'(bus.busy), 32'd0);
    check({tag, ".held_product"}, bus.product, exp);
  endtask

  initial begin
    int done_seen;
    logic [15:0] ra;
    logic [15:0] rb;
    pass_cnt  = 0;
    total_cnt = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset.busy", 32'(bus.busy), 32'd0);
    check("reset.done", 32'(bus.done), 32'd0);
    check("reset.product", bus.product, 32'd0);
    check("reset.hi_nz", 32'(bus.hi_nz), 32'd0);

    // Start and reset at the same edge: reset wins
    bus.start = 1'b1;
    bus.a     = 16'd3;
    bus.b     = 16'd5;
    reset     = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b0;
    check("start_vs_reset.busy", 32'(bus.busy), 32'd0);

    // Basic
    start_op(16'd3, 16'd5);
    wait_done("basic", 16'd3, 16'd5, 0);
    check_after_done("basic", 32'h0000000F);

    // Max operands
    start_op(16'hFFFF, 16'hFFFF);
    wait_done("max", 16'hFFFF, 16'hFFFF, 0);
    check("max.literal", bus.product, 32'hFFFE0001);
    check_after_done("max", 32'hFFFE0001);

    // Zero and identity
    start_op(16'h1234, 16'h0000);
    wait_done("zero", 16'h1234, 16'h0000, 0);
    check_after_done("zero", 32'h0);
    start_op(16'h7FFF, 16'h0001);
    wait_done("identity", 16'h7FFF, 16'h0001, 0);
    check_after_done("identity", 32'h00007FFF);

    // Start while busy is ignored
    start_op(16'h0100, 16'h0100);
    wait_done("start_while_busy", 16'h0100, 16'h0100, 5);
    check_after_done("start_while_busy", 32'h00010000);
    done_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    check("start_while_busy.extra_done", 32'(done_seen), 32'd0);

    // Back-to-back launch from DONE
    start_op(16'd3, 16'd5);
    wait_done("b2b_first", 16'd3, 16'd5, 0);
    bus.start = 1'b1;
    bus.a     = 16'd2;
    bus.b     = 16'd7;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 16'($urandom);
    bus.b     = 16'($urandom);
    check("b2b.busy_rise", 32'(bus.busy), 32'd1);
    check("b2b.done_drop", 32'(bus.done), 32'd0);
    wait_done("b2b_second", 16'd2, 16'd7, 0);
    check_after_done("b2b_second", 32'h0000000E);

    // Reset mid-operation
    start_op(16'hFFFF, 16'hFFFF);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset.busy", 32'(bus.busy), 32'd0);
    check("midreset.done", 32'(bus.done), 32'd0);
    check("midreset.product", bus.product, 32'd0);
    check("midreset.hi_nz", 32'(bus.hi_nz), 32'd0);
    done_seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    check("midreset.no_done", 32'(done_seen), 32'd0);
    start_op(16'd3, 16'd5);
    wait_done("after_reset", 16'd3, 16'd5, 0);
    check_after_done("after_reset", 32'h0000000F);

    // Randomized operands against the arithmetic model
    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i == 0) rb = 16'h8000;
      if (i == 1) ra = 16'h0001;
      start_op(ra, rb);
      wait_done($sformatf("rand%0d", i), ra, rb, (i % 3 == 0) ? 8 : 0);
      check_after_done($sformatf("rand%0d", i), ref_product(ra, rb));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/mul_seq_16.md
# mul_seq_16

Sequential unsigned 16x16 multiplier controller that time-shares a single `adder_16` instance over 16 shift-and-add iterations to produce a 32-bit product. It sits beside the ALU in the single-cycle CPU datapath as a multi-cycle functional unit and is launched by a start/busy/done handshake from the control unit. It exists so multiplication costs one 16-bit adder rather than an array multiplier.

## Interface
Parameters:
- none. Width is fixed at 16 to match `adder_16`.

Ports:
- `clk`  in  1  Single clock; all state updates on the rising edge.
- `reset`  in  1  Synchronous, active-high reset.
- `start`  in  1  Launch request; sampled only in IDLE or DONE.
- `a`  in  16  Multiplicand; captured on the accepted `start` edge.
- `b`  in  16  Multiplier; captured on the accepted `start` edge.
- `busy`  out  1  High in the RUN state.
- `done`  out  1  High in the DONE state, for exactly 1 cycle per operation.
- `product`  out  32  `{acc, q}` register contents; valid while `done` = 1 and held until the next accepted `start`.
- `hi_nz`  out  1  Reduction OR of `product[31:16]`; high when the result does not fit in 16 bits.

## Operation
Registers:
- `mcand[15:0]`, `acc[15:0]`, `q[15:0]`
- `cnt[4:0]`
- `state` ∈ {IDLE, RUN, DONE}

Datapath:
- Exactly one `adder_16` instance: a = `acc`, b = `mcand`, cin = 0.
- Its `c_n` is the 17th sum bit. `c_n_minus_1` is unused.
- No other 16-bit adders are allowed. `cnt` uses a plain 5-bit increment.

Reset (any state, synchronous):
- state = IDLE.
- `mcand`, `acc`, `q`, `cnt` = 0.
- Therefore `busy` = 0, `done` = 0, `product` = 0, `hi_nz` = 0.

FSM:
- **IDLE:**
  - `start` = 1: load `mcand` ← `a`, `acc` ← 0, `q` ← `b`, `cnt` ← 0; go to RUN.
  - Otherwise hold all registers.
- **RUN**, one iteration per cycle:
  - If `q[0]` = 1: `{acc, q}` ← `{c_n, sum[15:0], q[15:1]}`.
  - If `q[0]` = 0: `{acc, q}` ← `{1'b0, acc, q[15:1]}`.
  - `cnt` ← `cnt` + 1. When `cnt` = 15 (the 16th iteration), go to DONE.
  - `start` is ignored. No early termination: every operation takes exactly 16 iterations.
- **DONE:**
  - `start` = 1: load exactly as in IDLE and go to RUN (back-to-back launch).
  - Otherwise go to IDLE with registers held, so `product` stays stable.

Arithmetic rules:
- Unsigned only.
- The adder carry-out shifts into `acc[15]`, so no product bit is lost.
- Final `product` = `a` × `b` mod 2^32, which is always exact.
- `hi_nz` = |`acc`, computed combinationally from the registers.

## Timing
- `start` is accepted at edge E0 (state IDLE or DONE).
- Iterations complete at edges E1 through E16.
- State becomes DONE after E16, so `done` is high in the cycle between E16 and E17.
- Latency: `start` accepted → `done` = 17 cycles.
- Throughput: one product per 17 cycles with back-to-back `start`.
- `busy` is high for the 16 cycles following E0. `busy` and `done` are never high together.
- `a` and `b` are don't-care after E0.
- `reset` high at any edge, including mid-RUN, aborts the operation. `done` is not asserted for the aborted operation.
- `start` and `reset` at the same edge: `reset` wins.
- Outputs are registered state or combinational decode of state. There is no combinational path from `start` to `busy` or `done`.

## Test plan
- **Basic:** `a` = 3, `b` = 5, `start` pulse.
  - `busy` high for 16 cycles.
  - `done` high exactly 1 cycle, 17 cycles after `start`.
  - `product` = 0x0000000F, `hi_nz` = 0.
- **Max operands:** `a` = `b` = 0xFFFF.
  - `product` = 0xFFFE0001, `hi_nz` = 1.
  - Also confirms `c_n` is captured into `acc[15]`.
- **Zero and identity:**
  - `a` = 0x1234, `b` = 0 → `product` = 0.
  - `a` = 0x7FFF, `b` = 1 → `product` = 0x00007FFF, `hi_nz` = 0.
- **Start while busy:** pulse `start` with `a` = 9, `b` = 9 at cycle 5 of a 0x0100 × 0x0100 operation.
  - The second request is ignored.
  - `product` = 0x00010000, `hi_nz` = 1.
  - `done` fires once, at cycle 17.
- **Back-to-back:** assert `start` (`a` = 2, `b` = 7) during the DONE cycle of the previous 3 × 5 operation.
  - 0x0F is visible during DONE.
  - `busy` rises the next cycle.
  - The second `done` arrives 17 cycles later with `product` = 0x0000000E.
- **Reset mid-operation:** assert `reset` for 1 cycle at cycle 8 of 0xFFFF × 0xFFFF.
  - Next cycle: `busy` = 0, `done` = 0, `product` = 0.
  - No `done` pulse follows.
  - A fresh 3 × 5 operation then completes normally.
